// File: rtl/d_inst_recv.sv
// Decode receive stage: pairs fetch-stage entries with in-order inst responses (bypass or small FIFO).
// Bypass binds on the data_ok edge, FIFO words bind one cycle after capture; holds the entry while allowin_next=0.

module d_inst_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module d_inst_recv #(
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 2,
    parameter logic [31:0] RESET_PC   = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_last,
    output logic        allowin,
    input  logic [31:0] pc_in,
    input  logic [4:0]  exc_in,
    input  logic [31:0] badVAddr_in,
    input  logic        bd_in,
    input  logic        inst_req,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        flush,
    input  logic        allowin_next,
    output logic        valid,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [4:0]  exc_o,
    output logic [31:0] badVAddr_o,
    output logic        bdOut,
    output logic        proto_err
);
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] badvaddr;
        logic        bd;
    } meta_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meta_t            meta_q;
    logic             valid_r, instr_ok;
    logic [CNT_W-1:0] outstanding, discard;
    logic [31:0]      fifo_head;
    logic             fifo_empty, fifo_full;

    logic ready_go, capture, need_word, bind_fifo, rsp_live, bypass, push_req, req_acc;

    assign pc_out     = meta_q.pc;
    assign exc_o      = meta_q.exc;
    assign badVAddr_o = meta_q.badvaddr;
    assign bdOut      = meta_q.bd;

    assign ready_go  = valid_r && (instr_ok || meta_q.exc != 5'd0);
    assign allowin   = !valid_r || (ready_go && allowin_next);
    assign valid     = ready_go;
    assign capture   = allowin && valid_last && !flush;
    assign need_word = valid_r && !instr_ok && meta_q.exc == 5'd0;
    assign bind_fifo = need_word && !fifo_empty && !flush;
    // Words for the squashed path and any word in the flush cycle never reach the entry or FIFO.
    assign rsp_live  = inst_data_ok && discard == '0 && !flush;
    assign bypass    = rsp_live && need_word && fifo_empty;
    assign push_req  = rsp_live && !bypass;
    assign req_acc   = inst_req && inst_addr_ok;

    d_inst_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (push_req),
        .push_dat (inst_rdata),
        .pop      (bind_fifo),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (req_acc && !inst_data_ok && outstanding != CNT_MAX)
                outstanding <= outstanding + 1'b1;
            else if (!req_acc && inst_data_ok && outstanding != '0)
                outstanding <= outstanding - 1'b1;

            // Only requests accepted before this cycle belong to the squashed path.
            if (flush)
                discard <= (inst_data_ok && outstanding != '0) ? outstanding - 1'b1 : outstanding;
            else if (inst_data_ok && discard != '0)
                discard <= discard - 1'b1;

            if ((push_req && fifo_full) || (inst_data_ok && outstanding == '0))
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r   <= 1'b0;
            instr_ok  <= 1'b0;
            meta_q    <= '{pc: RESET_PC, exc: 5'd0, badvaddr: 32'd0, bd: 1'b0};
            instr_out <= 32'd0;
        end else if (flush) begin
            valid_r  <= 1'b0;
            instr_ok <= 1'b0;
        end else if (capture) begin
            valid_r  <= 1'b1;
            instr_ok <= 1'b0;
            meta_q   <= '{pc: pc_in, exc: exc_in, badvaddr: badVAddr_in, bd: bd_in};
            if (exc_in != 5'd0) instr_out <= 32'd0;
        end else begin
            if (ready_go && allowin_next) valid_r <= 1'b0;
            if (bind_fifo) begin
                instr_out <= fifo_head;
                instr_ok  <= 1'b1;
            end else if (bypass) begin
                instr_out <= inst_rdata;
                instr_ok  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_d_inst_recv.sv
// Directed bench for d_inst_recv: fetch/bind timing, backpressure, flush discard, AdEL, protocol errors.
module tb_d_inst_recv;
    logic        clk = 1'b0;
    logic        reset, valid_last, allowin, bd_in, inst_req, inst_addr_ok, inst_data_ok;
    logic        flush, allowin_next, valid, bdOut, proto_err;
    logic [31:0] pc_in, badVAddr_in, inst_rdata, pc_out, instr_out, badVAddr_o;
    logic [4:0]  exc_in, exc_o;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    d_inst_recv #(.FIFO_DEPTH(2), .CNT_W(2), .RESET_PC(32'hbfc00000)) dut (
        .clk(clk), .reset(reset), .valid_last(valid_last), .allowin(allowin),
        .pc_in(pc_in), .exc_in(exc_in), .badVAddr_in(badVAddr_in), .bd_in(bd_in),
        .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .flush(flush), .allowin_next(allowin_next),
        .valid(valid), .pc_out(pc_out), .instr_out(instr_out), .exc_o(exc_o),
        .badVAddr_o(badVAddr_o), .bdOut(bdOut), .proto_err(proto_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        valid_last = 0; inst_req = 0; inst_addr_ok = 0; inst_data_ok = 0;
        flush = 0; exc_in = 5'd0; bd_in = 0; badVAddr_in = 32'd0;
    endtask

    task automatic do_reset;
        idle(); reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic test_reset;
        allowin_next = 1; pc_in = 32'd0; inst_rdata = 32'd0;
        do_reset();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got %b want 1", allowin); end
        tests++; if (pc_out !== 32'hbfc00000) begin fails++; $display("FAIL reset_pc got %h want bfc00000", pc_out); end
        tests++; if (instr_out !== 32'd0) begin fails++; $display("FAIL reset_instr got %h want 0", instr_out); end
        tests++; if (exc_o !== 5'd0 || badVAddr_o !== 32'd0 || bdOut !== 1'b0) begin
            fails++; $display("FAIL reset_meta got exc=%h bad=%h bd=%b want 0", exc_o, badVAddr_o, bdOut); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto got %b want 0", proto_err); end
    endtask

    task automatic test_basic_fetch;
        valid_last = 1; pc_in = 32'hbfc00000; inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_t1_valid got %b want 0", valid); end
        tick();
        inst_data_ok = 1; inst_rdata = 32'h3c1d0001;
        tick(); idle();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL basic_t3_valid got %b want 1", valid); end
        tests++; if (pc_out !== 32'hbfc00000) begin fails++; $display("FAIL basic_pc got %h want bfc00000", pc_out); end
        tests++; if (instr_out !== 32'h3c1d0001) begin fails++; $display("FAIL basic_instr got %h want 3c1d0001", instr_out); end
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_leave got %b want 0", valid); end
    endtask

    task automatic test_backpressure;
        valid_last = 1; pc_in = 32'hbfc00004; inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        inst_data_ok = 1; inst_rdata = 32'h24020001; inst_req = 1; inst_addr_ok = 1; allowin_next = 0;
        tick(); idle();
        inst_data_ok = 1; inst_rdata = 32'h55555555;
        tick(); idle();
        for (int i = 0; i < 5; i++) begin
            tests++; if (valid !== 1'b1 || allowin !== 1'b0) begin
                fails++; $display("FAIL bp_hold[%0d] got valid=%b allowin=%b want 1/0", i, valid, allowin); end
            tests++; if (instr_out !== 32'h24020001 || pc_out !== 32'hbfc00004) begin
                fails++; $display("FAIL bp_stable[%0d] got pc=%h instr=%h want bfc00004/24020001", i, pc_out, instr_out); end
            tick();
        end
        allowin_next = 1; valid_last = 1; pc_in = 32'hbfc00008;
        #1;
        tests++; if (allowin !== 1'b1) begin fails++; $display("FAIL bp_release got %b want 1", allowin); end
        tick(); idle();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL bp_no_same_cycle_bind got %b want 0", valid); end
        tick();
        tests++; if (valid !== 1'b1 || instr_out !== 32'h55555555 || pc_out !== 32'hbfc00008) begin
            fails++; $display("FAIL bp_fifo_bind got v=%b pc=%h instr=%h want 1/bfc00008/55555555", valid, pc_out, instr_out); end
        tick();
    endtask

    task automatic test_early_response;
        inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        inst_data_ok = 1; inst_rdata = 32'h11111111;
        tick(); idle();
        valid_last = 1; pc_in = 32'hbfc0000c;
        tick(); idle();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL early_capture_valid got %b want 0", valid); end
        tick();
        tests++; if (valid !== 1'b1 || instr_out !== 32'h11111111) begin
            fails++; $display("FAIL early_bind got v=%b instr=%h want 1/11111111", valid, instr_out); end
        tick();
    endtask

    task automatic test_flush;
        valid_last = 1; pc_in = 32'hbfc00010; inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        flush = 1; inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        tests++; if (valid !== 1'b0 || allowin !== 1'b1) begin
            fails++; $display("FAIL flush_clear got v=%b allowin=%b want 0/1", valid, allowin); end
        valid_last = 1; pc_in = 32'hbfc00380; inst_data_ok = 1; inst_rdata = 32'hdeadbeef;
        tick(); idle();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL flush_drop_valid got %b want 0", valid); end
        inst_data_ok = 1; inst_rdata = 32'h24080005;
        tick(); idle();
        tests++; if (valid !== 1'b1 || pc_out !== 32'hbfc00380 || instr_out !== 32'h24080005) begin
            fails++; $display("FAIL flush_rebind got v=%b pc=%h instr=%h want 1/bfc00380/24080005", valid, pc_out, instr_out); end
        tick();
    endtask

    task automatic test_adel;
        inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        inst_data_ok = 1; inst_rdata = 32'h77777777;
        tick(); idle();
        valid_last = 1; exc_in = 5'd4; pc_in = 32'hbfc00002; badVAddr_in = 32'hbfc00002; bd_in = 1;
        tick(); idle();
        tests++; if (valid !== 1'b1 || instr_out !== 32'd0) begin
            fails++; $display("FAIL adel_ready got v=%b instr=%h want 1/0", valid, instr_out); end
        tests++; if (exc_o !== 5'd4 || badVAddr_o !== 32'hbfc00002 || bdOut !== 1'b1) begin
            fails++; $display("FAIL adel_meta got exc=%h bad=%h bd=%b want 4/bfc00002/1", exc_o, badVAddr_o, bdOut); end
        valid_last = 1; pc_in = 32'hbfc00020;
        tick(); idle();
        tests++; if (valid !== 1'b0 || exc_o !== 5'd0) begin
            fails++; $display("FAIL adel_next_capture got v=%b exc=%h want 0/0", valid, exc_o); end
        tick();
        tests++; if (valid !== 1'b1 || instr_out !== 32'h77777777) begin
            fails++; $display("FAIL adel_fifo_untouched got v=%b instr=%h want 1/77777777", valid, instr_out); end
        tick();
    endtask

    task automatic test_proto_err;
        inst_req = 1; inst_addr_ok = 1;
        tick(); tick(); tick(); idle();
        inst_data_ok = 1; inst_rdata = 32'ha0a0a0a0; tick();
        inst_rdata = 32'hb1b1b1b1; tick(); idle();
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL proto_two_ok got %b want 0", proto_err); end
        inst_data_ok = 1; inst_rdata = 32'hc2c2c2c2;
        tick(); idle();
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_overflow got %b want 1", proto_err); end
        tick(); tick(); tick();
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_sticky got %b want 1", proto_err); end
        valid_last = 1; pc_in = 32'hbfc00030; tick(); idle(); tick();
        tests++; if (valid !== 1'b1 || instr_out !== 32'ha0a0a0a0) begin
            fails++; $display("FAIL proto_first got v=%b instr=%h want 1/a0a0a0a0", valid, instr_out); end
        valid_last = 1; pc_in = 32'hbfc00034; tick(); idle(); tick();
        tests++; if (valid !== 1'b1 || instr_out !== 32'hb1b1b1b1 || pc_out !== 32'hbfc00034) begin
            fails++; $display("FAIL proto_second got v=%b pc=%h instr=%h want 1/bfc00034/b1b1b1b1", valid, pc_out, instr_out); end
        valid_last = 1; pc_in = 32'hbfc00038; tick(); idle(); tick(); tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL proto_third_dropped got %b want 0", valid); end
        do_reset();
        tests++; if (proto_err !== 1'b0 || valid !== 1'b0) begin
            fails++; $display("FAIL proto_reset got err=%b v=%b want 0/0", proto_err, valid); end
        inst_data_ok = 1; inst_rdata = 32'h12345678;
        tick(); idle();
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_zero_outstanding got %b want 1", proto_err); end
        do_reset();
    endtask

    task automatic test_reset_mid;
        inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        flush = 1;
        tick(); idle();
        do_reset();
        valid_last = 1; pc_in = 32'hbfc00040; inst_req = 1; inst_addr_ok = 1;
        tick(); idle();
        inst_data_ok = 1; inst_rdata = 32'h99999999;
        tick(); idle();
        tests++; if (valid !== 1'b1 || instr_out !== 32'h99999999) begin
            fails++; $display("FAIL reset_mid_no_discard got v=%b instr=%h want 1/99999999", valid, instr_out); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_mid_proto got %b want 0", proto_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_early_response();
        test_flush();
        test_adel();
        test_proto_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
